// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core and the debug/loader
// requester; each access runs issue, wait and response phases and ends in a done pulse.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_done,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_dbg_q, last_dbg_d;
  logic              own_dbg_q, own_dbg_d;
  logic              acc_we_q, acc_we_d;
  logic              core_done_q, core_done_d;
  logic              dbg_done_q, dbg_done_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              pick_dbg;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_dbg_d   = last_dbg_q;
    own_dbg_d    = own_dbg_q;
    acc_we_d     = acc_we_q;
    core_done_d  = 1'b0;
    dbg_done_d   = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    // Debug wins only when it is alone or the core was served last.
    pick_dbg     = dbg_req & (~core_req | ~last_dbg_q);

    case (state_q)
      S_IDLE: begin
        if (core_req | dbg_req) begin
          state_d     = S_ISSUE;
          own_dbg_d   = pick_dbg;
          last_dbg_d  = pick_dbg;
          acc_we_d    = pick_dbg ? dbg_we : core_we;
          mem_en_d    = 1'b1;
          mem_we_d    = acc_we_d;
          mem_addr_d  = pick_dbg ? dbg_addr : core_addr;
          mem_wdata_d = pick_dbg ? dbg_wdata : core_wdata;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Last wait cycle: memory data is valid now, so capture it for the owner.
        if (cnt_q == 4'd1) begin
          state_d     = S_RESP;
          core_done_d = ~own_dbg_q;
          dbg_done_d  = own_dbg_q;
          if (!acc_we_q) begin
            if (own_dbg_q) dbg_rdata_d  = mem_rdata;
            else           core_rdata_d = mem_rdata;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_dbg_q   <= 1'b1;
      own_dbg_q    <= 1'b0;
      acc_we_q     <= 1'b0;
      core_done_q  <= 1'b0;
      dbg_done_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_dbg_q   <= last_dbg_d;
      own_dbg_q    <= own_dbg_d;
      acc_we_q     <= acc_we_d;
      core_done_q  <= core_done_d;
      dbg_done_q   <= dbg_done_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign core_done  = core_done_q;
  assign dbg_done   = dbg_done_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rdata = core_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) driven by directed
// and random requesters, compared each cycle against a transaction-timing model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic [1:0]       core_req, core_we, dbg_req, dbg_we;
  logic [1:0][31:0] core_addr, core_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic [1:0]       core_done, dbg_done, mem_en, mem_we, busy;
  logic [1:0][31:0] core_rdata, dbg_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn),
    .core_req(core_req[0]), .core_we(core_we[0]), .core_addr(core_addr[0]),
    .core_wdata(core_wdata[0]), .core_done(core_done[0]), .core_rdata(core_rdata[0]),
    .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]),
    .dbg_wdata(dbg_wdata[0]), .dbg_done(dbg_done[0]), .dbg_rdata(dbg_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn),
    .core_req(core_req[1]), .core_we(core_we[1]), .core_addr(core_addr[1]),
    .core_wdata(core_wdata[1]), .core_done(core_done[1]), .core_rdata(core_rdata[1]),
    .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]),
    .dbg_wdata(dbg_wdata[1]), .dbg_done(dbg_done[1]), .dbg_rdata(dbg_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat [2] = '{1, 3};

  // Model: one access in flight, described by its grant cycle g; every output is a
  // function of the distance from g.
  bit          act [2];
  int          g [2];
  bit          gd [2], gwe [2], last_dbg [2];
  logic [31:0] gaddr [2], gwdata [2], sh_addr [2], sh_wdata [2];
  logic [31:0] rd [2][2];
  logic [31:0] hist [2][16];
  bit          e_en [2], e_we [2], e_busy [2], e_cd [2], e_dd [2];
  bit          pend [2][2];

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [MEM_LAT=%0d] cyc=%0d got=%h expected=%h", nm, lat[i], cyc, got, exp);
    end
  endtask

  task automatic model_clear(input int i);
    act[i] = 1'b0; last_dbg[i] = 1'b1;
    sh_addr[i] = '0; sh_wdata[i] = '0;
    rd[i][0] = '0; rd[i][1] = '0;
  endtask

  // Inputs of the current cycle: remember memory data, apply reset or a grant.
  task automatic model_sample(input int i);
    bit d;
    hist[i][cyc % 16] = mem_rdata[i];
    if (!resetn) begin
      model_clear(i);
    end else if (!act[i] && (core_req[i] || dbg_req[i])) begin
      d = dbg_req[i] && (!core_req[i] || !last_dbg[i]);
      act[i] = 1'b1; g[i] = cyc; gd[i] = d; last_dbg[i] = d;
      gwe[i]    = d ? dbg_we[i]    : core_we[i];
      gaddr[i]  = d ? dbg_addr[i]  : core_addr[i];
      gwdata[i] = d ? dbg_wdata[i] : core_wdata[i];
    end
  endtask

  task automatic model_retire(input int i);
    int L;
    L = lat[i];
    if (act[i] && cyc == g[i] + 1) begin
      sh_addr[i] = gaddr[i]; sh_wdata[i] = gwdata[i];
    end
    if (act[i] && cyc == g[i] + 2 + L && !gwe[i])
      rd[i][gd[i]] = hist[i][(g[i] + 1 + L) % 16];
    if (act[i] && cyc == g[i] + 3 + L) act[i] = 1'b0;
    e_en[i]   = act[i] && cyc == g[i] + 1;
    e_we[i]   = e_en[i] && gwe[i];
    e_busy[i] = act[i] && cyc >= g[i] + 1 && cyc <= g[i] + 2 + L;
    e_cd[i]   = act[i] && cyc == g[i] + 2 + L && !gd[i];
    e_dd[i]   = act[i] && cyc == g[i] + 2 + L && gd[i];
  endtask

  task automatic compare(input int i);
    chk("busy",       i, busy[i],       e_busy[i]);
    chk("mem_en",     i, mem_en[i],     e_en[i]);
    chk("mem_we",     i, mem_we[i],     e_we[i]);
    chk("core_done",  i, core_done[i],  e_cd[i]);
    chk("dbg_done",   i, dbg_done[i],   e_dd[i]);
    chk("mem_addr",   i, mem_addr[i],   sh_addr[i]);
    chk("mem_wdata",  i, mem_wdata[i],  sh_wdata[i]);
    chk("core_rdata", i, core_rdata[i], rd[i][0]);
    chk("dbg_rdata",  i, dbg_rdata[i],  rd[i][1]);
  endtask

  task automatic tick();
    for (int i = 0; i < 2; i++) model_sample(i);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      model_retire(i);
      compare(i);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int      ports [$];
    int      when  [$];
    bit      found;
    bit      d;
    resetn = 1'b0;
    core_req = '0; core_we = '0; dbg_req = '0; dbg_we = '0;
    core_addr = '0; core_wdata = '0; dbg_addr = '0; dbg_wdata = '0; mem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      model_clear(i);
      pend[i][0] = 1'b0; pend[i][1] = 1'b0;
    end

    repeat (3) tick();
    chk("rst_busy",     0, busy[0],       0);
    chk("rst_mem_addr", 1, mem_addr[1],   0);
    chk("rst_rdata",    0, core_rdata[0], 0);

    // Single reads on both instances
    resetn = 1'b1;
    core_req[0] = 1'b1; core_addr[0] = 32'h10; mem_rdata[0] = 32'hDEADBEEF;
    dbg_req[1]  = 1'b1; dbg_addr[1]  = 32'h8;  mem_rdata[1] = 32'hA5A5A5A5;
    tick();
    chk("A_mem_en",   0, mem_en[0],   1);
    chk("A_mem_addr", 0, mem_addr[0], 32'h10);
    chk("A_mem_we",   0, mem_we[0],   0);
    chk("A3_mem_en",  1, mem_en[1],   1);
    tick(); tick();
    chk("A_core_done",  0, core_done[0],  1);
    chk("A_core_rdata", 0, core_rdata[0], 32'hDEADBEEF);
    chk("A_dbg_done",   0, dbg_done[0],   0);
    core_req[0] = 1'b0;
    tick(); tick();
    chk("A3_dbg_done",  1, dbg_done[1],  1);
    chk("A3_dbg_rdata", 1, dbg_rdata[1], 32'hA5A5A5A5);
    chk("A3_busy_t5",   1, busy[1],      1);
    dbg_req[1] = 1'b0;
    tick();
    chk("A3_busy_t6", 1, busy[1], 0);

    // Simultaneous requests right after reset: core first, then debug write
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    core_req[0] = 1'b1; core_we[0] = 1'b0; core_addr[0] = 32'h20;
    dbg_req[0]  = 1'b1; dbg_we[0]  = 1'b1; dbg_addr[0]  = 32'h30; dbg_wdata[0] = 32'h55;
    tick(); tick(); tick();
    chk("B_core_done", 0, core_done[0], 1);
    core_req[0] = 1'b0;
    tick(); tick();
    chk("B_mem_en",    0, mem_en[0],    1);
    chk("B_mem_we",    0, mem_we[0],    1);
    chk("B_mem_addr",  0, mem_addr[0],  32'h30);
    chk("B_mem_wdata", 0, mem_wdata[0], 32'h55);
    tick(); tick();
    chk("B_dbg_done",  0, dbg_done[0],  1);
    dbg_req[0] = 1'b0; dbg_we[0] = 1'b0;
    tick();

    // Debug read of 0x1234, then a write must leave dbg_rdata alone
    dbg_req[0] = 1'b1; dbg_addr[0] = 32'h44; mem_rdata[0] = 32'h1234;
    tick(); tick(); tick();
    chk("W_rd_rdata", 0, dbg_rdata[0], 32'h1234);
    dbg_req[0] = 1'b0;
    tick();
    dbg_req[0] = 1'b1; dbg_we[0] = 1'b1; dbg_addr[0] = 32'h40; mem_rdata[0] = 32'hFFFFFFFF;
    tick(); tick(); tick();
    chk("W_wr_done",  0, dbg_done[0],  1);
    chk("W_wr_rdata", 0, dbg_rdata[0], 32'h1234);
    dbg_req[0] = 1'b0; dbg_we[0] = 1'b0;
    tick();

    // Both held high: alternating grants, one done every 4 cycles
    core_req[0] = 1'b1; core_addr[0] = 32'h100;
    dbg_req[0]  = 1'b1; dbg_addr[0]  = 32'h200;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (core_done[0]) begin ports.push_back(0); when.push_back(cyc); end
      if (dbg_done[0])  begin ports.push_back(1); when.push_back(cyc); end
    end
    core_req[0] = 1'b0; dbg_req[0] = 1'b0;
    chk("RR_count", 0, ports.size(), 4);
    for (int k = 0; k < ports.size() && k < 4; k++) begin
      chk("RR_order", 0, ports[k], k % 2);
      if (k > 0) chk("RR_period", 0, when[k] - when[k-1], 4);
    end
    tick(); tick();

    // Reset during WAIT of a MEM_LAT=3 core read; held request is re-granted
    core_req[1] = 1'b1; core_we[1] = 1'b0; core_addr[1] = 32'h300; mem_rdata[1] = 32'hCAFEF00D;
    tick(); tick();
    resetn = 1'b0;
    tick();
    chk("D_busy",      1, busy[1],      0);
    chk("D_core_done", 1, core_done[1], 0);
    resetn = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (core_done[1]) begin
        found = 1'b1;
        chk("D_rdata", 1, core_rdata[1], 32'hCAFEF00D);
        core_req[1] = 1'b0;
      end
    end
    chk("D_regrant_done", 1, found, 1);
    core_req[1] = 1'b0;
    tick(); tick();

    // Random traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          d = (p == 1) ? e_dd[i] : e_cd[i];
          if (d) begin
            pend[i][p] = 1'b0;
            if (p == 1) dbg_req[i] = 1'b0; else core_req[i] = 1'b0;
          end
          if (!pend[i][p] && $urandom_range(0, 99) < 35) begin
            pend[i][p] = 1'b1;
            if (p == 1) begin
              dbg_req[i] = 1'b1; dbg_we[i] = 1'($urandom);
              dbg_addr[i] = $urandom; dbg_wdata[i] = $urandom;
            end else begin
              core_req[i] = 1'b1; core_we[i] = 1'($urandom);
              core_addr[i] = $urandom; core_wdata[i] = $urandom;
            end
          end
        end
        mem_rdata[i] = $urandom;
      end
      resetn = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
